// File: rtl/fp_variant_diff_checker.sv
`default_nettype none
// ============================================================================
// Module   : fp_variant_diff_checker
// Brief    : Re-aligns NUM_VAR FP operator variants to a common latency,
//            compares them against a reference and captures the first mismatch.
// Revision : 1.0
// ============================================================================
module fp_variant_diff_checker #(
  parameter int                   WIDTH   = 32,
  parameter int                   FLAG_W  = 3,
  parameter int                   NUM_VAR = 4,
  parameter int                   MAX_LAT = 4,
  parameter logic [4*NUM_VAR-1:0] LAT_VEC = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter int                   REF_IDX = 0,
  parameter int                   CNT_W   = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          issue_valid,
  input  logic [WIDTH-1:0]                              issue_a,
  input  logic [WIDTH-1:0]                              issue_b,
  input  logic [NUM_VAR*WIDTH-1:0]                      var_result,
  input  logic [NUM_VAR*((FLAG_W > 0) ? FLAG_W : 1)-1:0] var_flags,
  input  logic                                          stop_on_first,
  input  logic                                          clear,
  output logic                                          chk_valid,
  output logic [NUM_VAR-1:0]                            chk_mask,
  output logic [CNT_W-1:0]                              cmp_count,
  output logic [CNT_W-1:0]                              err_count,
  output logic                                          err_sticky,
  output logic [WIDTH-1:0]                              cap_a,
  output logic [WIDTH-1:0]                              cap_b,
  output logic [NUM_VAR-1:0]                            cap_mask,
  output logic [CNT_W-1:0]                              cap_index,
  output logic                                          frozen
);

  localparam int               FW        = (FLAG_W > 0) ? FLAG_W : 1;
  localparam int               PW        = WIDTH + FW;
  localparam logic [FW-1:0]    FLAG_MASK = {FW{(FLAG_W > 0)}};
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {ST_CHECK = 1'b0, ST_FROZEN = 1'b1} state_t;

  if ((REF_IDX < 0) || (REF_IDX >= NUM_VAR)) begin : g_bad_ref
    $error("fp_variant_diff_checker: REF_IDX out of range");
  end

  logic [PW-1:0] dly_out [NUM_VAR];

  // Each variant is delayed by MAX_LAT-LAT_i registers so all land together.
  for (genvar gi = 0; gi < NUM_VAR; gi++) begin : g_var
    localparam int LAT = int'(LAT_VEC[4*gi +: 4]);
    localparam int DLY = MAX_LAT - LAT;
    logic [PW-1:0] in_w;
    assign in_w = {var_flags[FW*gi +: FW] & FLAG_MASK, var_result[WIDTH*gi +: WIDTH]};

    if (LAT > MAX_LAT) begin : g_bad_lat
      $error("fp_variant_diff_checker: LAT_VEC entry exceeds MAX_LAT");
    end

    if (DLY <= 0) begin : g_nodly
      assign dly_out[gi] = in_w;
    end else begin : g_dly
      logic [PW-1:0] dly_q [DLY];
      logic [PW-1:0] dly_d [DLY];
      always_comb begin
        dly_d[0] = in_w;
        for (int k = 1; k < DLY; k++) dly_d[k] = dly_q[k-1];
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end
      assign dly_out[gi] = dly_q[DLY-1];
    end
  end

  logic [MAX_LAT-1:0]            iss_vld_q, iss_vld_d;
  logic [MAX_LAT-1:0][WIDTH-1:0] iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic                          aln_vld_q;
  logic [WIDTH-1:0]              aln_a_q, aln_b_q;
  logic [PW-1:0]                 aln_pay_q [NUM_VAR];

  always_comb begin
    iss_vld_d[0] = issue_valid;
    iss_a_d[0]   = issue_a;
    iss_b_d[0]   = issue_b;
    for (int k = 1; k < MAX_LAT; k++) begin
      iss_vld_d[k] = iss_vld_q[k-1];
      iss_a_d[k]   = iss_a_q[k-1];
      iss_b_d[k]   = iss_b_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_vld_q <= '0;
      iss_a_q   <= '0;
      iss_b_q   <= '0;
      aln_vld_q <= 1'b0;
      aln_a_q   <= '0;
      aln_b_q   <= '0;
      for (int k = 0; k < NUM_VAR; k++) aln_pay_q[k] <= '0;
    end else begin
      iss_vld_q <= iss_vld_d;
      iss_a_q   <= iss_a_d;
      iss_b_q   <= iss_b_d;
      aln_vld_q <= iss_vld_q[MAX_LAT-1];
      aln_a_q   <= iss_a_q[MAX_LAT-1];
      aln_b_q   <= iss_b_q[MAX_LAT-1];
      aln_pay_q <= dly_out;
    end
  end

  logic [NUM_VAR-1:0] diff_mask;
  logic               mismatch;

  always_comb begin
    diff_mask = '0;
    for (int i = 0; i < NUM_VAR; i++) begin
      if ((i != REF_IDX) && (aln_pay_q[i] != aln_pay_q[REF_IDX])) diff_mask[i] = 1'b1;
    end
    mismatch = |diff_mask;
  end

  state_t             state_q, state_d;
  logic               chk_valid_q, chk_valid_d, sticky_q, sticky_d;
  logic [NUM_VAR-1:0] chk_mask_q, chk_mask_d, cap_mask_q, cap_mask_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d, err_q, err_d, cap_idx_q, cap_idx_d;
  logic [WIDTH-1:0]   cap_a_q, cap_a_d, cap_b_q, cap_b_d;

  always_comb begin
    state_d     = state_q;
    chk_valid_d = aln_vld_q;
    chk_mask_d  = aln_vld_q ? diff_mask : chk_mask_q;
    cmp_d       = cmp_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    cap_mask_d  = cap_mask_q;
    cap_idx_d   = cap_idx_q;
    if (clear) begin
      // Pipeline keeps flowing; only the bookkeeping is wiped.
      state_d    = ST_CHECK;
      cmp_d      = '0;
      err_d      = '0;
      sticky_d   = 1'b0;
      cap_a_d    = '0;
      cap_b_d    = '0;
      cap_mask_d = '0;
      cap_idx_d  = '0;
    end else if (aln_vld_q && (state_q == ST_CHECK)) begin
      if (cmp_q != CNT_MAX) cmp_d = cmp_q + 1'b1;
      if (mismatch) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (!sticky_q) begin
          sticky_d   = 1'b1;
          cap_a_d    = aln_a_q;
          cap_b_d    = aln_b_q;
          cap_mask_d = diff_mask;
          cap_idx_d  = cmp_q;
        end
        if (stop_on_first) state_d = ST_FROZEN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CHECK;
      chk_valid_q <= 1'b0;
      chk_mask_q  <= '0;
      cmp_q       <= '0;
      err_q       <= '0;
      sticky_q    <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_mask_q  <= '0;
      cap_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= chk_valid_d;
      chk_mask_q  <= chk_mask_d;
      cmp_q       <= cmp_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_mask_q  <= cap_mask_d;
      cap_idx_q   <= cap_idx_d;
    end
  end

  assign chk_valid  = chk_valid_q;
  assign chk_mask   = chk_mask_q;
  assign cmp_count  = cmp_q;
  assign err_count  = err_q;
  assign err_sticky = sticky_q;
  assign cap_a      = cap_a_q;
  assign cap_b      = cap_b_q;
  assign cap_mask   = cap_mask_q;
  assign cap_index  = cap_idx_q;
  assign frozen     = (state_q == ST_FROZEN);

endmodule
`default_nettype wire

// File: tb/tb_fp_variant_diff_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_variant_diff_checker
// Brief    : Self-checking bench: directed sequences, vector table and random
//            traffic checked against an op-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fp_variant_diff_checker;

  localparam int W   = 32;
  localparam int FW  = 3;
  localparam int NV  = 4;
  localparam int ML  = 4;
  localparam int REF = 0;
  localparam int HN  = 4096;

  int LAT [NV] = '{1, 2, 3, 4};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              issue_valid = 1'b0;
  logic [W-1:0]      issue_a = '0, issue_b = '0;
  logic [NV*W-1:0]   var_result = '0;
  logic [NV*FW-1:0]  var_flags = '0;
  logic              stop_on_first = 1'b0;
  logic              clear = 1'b0;

  logic              chk_valid, err_sticky, frozen;
  logic [NV-1:0]     chk_mask, cap_mask;
  logic [15:0]       cmp_count, err_count, cap_index;
  logic [W-1:0]      cap_a, cap_b;

  logic              s_chk_valid, s_err_sticky, s_frozen;
  logic [NV-1:0]     s_chk_mask, s_cap_mask;
  logic [3:0]        s_cmp_count, s_err_count, s_cap_index;
  logic [W-1:0]      s_cap_a, s_cap_b;

  fp_variant_diff_checker dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
    .var_result(var_result), .var_flags(var_flags), .stop_on_first(stop_on_first), .clear(clear),
    .chk_valid(chk_valid), .chk_mask(chk_mask), .cmp_count(cmp_count), .err_count(err_count),
    .err_sticky(err_sticky), .cap_a(cap_a), .cap_b(cap_b), .cap_mask(cap_mask),
    .cap_index(cap_index), .frozen(frozen)
  );

  fp_variant_diff_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
    .var_result(var_result), .var_flags(var_flags), .stop_on_first(stop_on_first), .clear(clear),
    .chk_valid(s_chk_valid), .chk_mask(s_chk_mask), .cmp_count(s_cmp_count), .err_count(s_err_count),
    .err_sticky(s_err_sticky), .cap_a(s_cap_a), .cap_b(s_cap_b), .cap_mask(s_cap_mask),
    .cap_index(s_cap_index), .frozen(s_frozen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                   v;
    logic                   clr;
    logic                   sof;
    logic [W-1:0]           a;
    logic [W-1:0]           b;
    logic [NV-1:0][W-1:0]   r;
    logic [NV-1:0][FW-1:0]  f;
  } hist_t;

  typedef struct packed {
    logic [W-1:0]           a;
    logic [W-1:0]           b;
    logic [NV-1:0][W-1:0]   r;
    logic [NV-1:0][FW-1:0]  f;
    logic [NV-1:0]          exp_mask;
  } vec_t;

  hist_t hist [HN];
  int    n = 0;
  int    tests = 0;
  int    fails = 0;

  logic                  p_v = 1'b0, p_clr = 1'b0, p_sof = 1'b0;
  logic [W-1:0]          p_a = '0, p_b = '0;
  logic [NV-1:0][W-1:0]  p_r = '0;
  logic [NV-1:0][FW-1:0] p_f = '0;

  // Reference model state: op-level view of what the checker should report.
  logic          e_valid = 1'b0, e_sticky = 1'b0, e_frozen = 1'b0;
  logic [NV-1:0] e_mask = '0, e_cap_mask = '0;
  int            e_cmp = 0, e_err = 0, e_scmp = 0, e_serr = 0, e_cap_idx = 0;
  logic [W-1:0]  e_cap_a = '0, e_cap_b = '0;

  int            pulses = 0, first_n = -1, last_n = -1;
  logic [NV-1:0] last_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [NV-1:0] mask_of(input hist_t h);
    logic [NV-1:0] m = '0;
    for (int i = 0; i < NV; i++)
      if (i != REF && (h.r[i] != h.r[REF] || h.f[i] != h.f[REF])) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_zero();
    e_cmp = 0; e_err = 0; e_scmp = 0; e_serr = 0;
    e_sticky = 1'b0; e_frozen = 1'b0;
    e_cap_a = '0; e_cap_b = '0; e_cap_mask = '0; e_cap_idx = 0;
  endtask

  task automatic model_update();
    int k = n - ML - 1;
    logic ev = (k >= 0) && hist[k].v;
    logic [NV-1:0] m = '0;
    if (ev) begin
      m = mask_of(hist[k]);
      e_mask = m;
    end
    e_valid = ev;
    if (hist[n].clr) begin
      model_zero();
    end else if (ev && !e_frozen) begin
      if (m != 0 && !e_sticky) begin
        e_sticky = 1'b1; e_cap_a = hist[k].a; e_cap_b = hist[k].b;
        e_cap_mask = m; e_cap_idx = e_cmp;
      end
      if (m != 0) begin
        e_err  = (e_err  < 65535) ? e_err + 1  : e_err;
        e_serr = (e_serr < 15)    ? e_serr + 1 : e_serr;
        if (hist[n].sof) e_frozen = 1'b1;
      end
      e_cmp  = (e_cmp  < 65535) ? e_cmp + 1  : e_cmp;
      e_scmp = (e_scmp < 15)    ? e_scmp + 1 : e_scmp;
    end
  endtask

  task automatic check_all();
    chk("chk_valid", chk_valid, e_valid);
    if (e_valid) chk("chk_mask", chk_mask, e_mask);
    chk("cmp_count", cmp_count, e_cmp);
    chk("err_count", err_count, e_err);
    chk("err_sticky", err_sticky, e_sticky);
    chk("frozen", frozen, e_frozen);
    chk("cap_a", cap_a, e_cap_a);
    chk("cap_b", cap_b, e_cap_b);
    chk("cap_mask", cap_mask, e_cap_mask);
    chk("cap_index", cap_index, e_cap_idx);
    chk("small_cmp_count", s_cmp_count, e_scmp);
    chk("small_err_count", s_err_count, e_serr);
  endtask

  // One clock: drive at negedge, model and compare just after the posedge.
  task automatic cycle();
    hist[n] = '{v: p_v, clr: p_clr, sof: p_sof, a: p_a, b: p_b, r: p_r, f: p_f};
    issue_valid   = p_v;
    issue_a       = p_a;
    issue_b       = p_b;
    clear         = p_clr;
    stop_on_first = p_sof;
    for (int i = 0; i < NV; i++) begin
      int k = n - LAT[i];
      if (k >= 0 && hist[k].v) begin
        var_result[i*W +: W]   = hist[k].r[i];
        var_flags[i*FW +: FW]  = hist[k].f[i];
      end else begin
        var_result[i*W +: W]   = $urandom;
        var_flags[i*FW +: FW]  = FW'($urandom);
      end
    end
    @(posedge clk);
    model_update();
    #1;
    check_all();
    if (chk_valid) begin
      pulses++;
      if (first_n < 0) first_n = n;
      last_n = n;
      last_mask = chk_mask;
    end
    n++;
    if (n >= HN) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", n, HN);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
    p_v = 1'b0;
    p_clr = 1'b0;
  endtask

  task automatic idle(input int m);
    repeat (m) cycle();
  endtask

  task automatic reset_pulses();
    pulses = 0; first_n = -1; last_n = -1;
  endtask

  task automatic plan_agree(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
    p_v = 1'b1; p_a = a; p_b = b;
    for (int i = 0; i < NV; i++) begin
      p_r[i] = r;
      p_f[i] = '0;
    end
  endtask

  task automatic do_clear();
    p_clr = 1'b1;
    cycle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_chk_valid"}, chk_valid, 0);
    chk({tag, "_chk_mask"}, chk_mask, 0);
    chk({tag, "_cmp_count"}, cmp_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
    chk({tag, "_frozen"}, frozen, 0);
    chk({tag, "_cap_a"}, cap_a, 0);
    chk({tag, "_cap_b"}, cap_b, 0);
    chk({tag, "_cap_mask"}, cap_mask, 0);
    chk({tag, "_cap_index"}, cap_index, 0);
    chk({tag, "_small_cmp"}, s_cmp_count, 0);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r0, input logic [W-1:0] r1,
                              input logic [W-1:0] r2, input logic [W-1:0] r3,
                              input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                              input logic [FW-1:0] f2, input logic [FW-1:0] f3,
                              input logic [NV-1:0] m);
    vec_t v;
    v.a = a; v.b = b;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.f[0] = f0; v.f[1] = f1; v.f[2] = f2; v.f[3] = f3;
    v.exp_mask = m;
    return v;
  endfunction

  initial begin
    vec_t            tab [7];
    logic [W-1:0]    op_a [8];
    logic [W-1:0]    op_b [8];
    int              n0;

    tab[0] = mk(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000);
    tab[1] = mk(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40400000, 32'h40400001, 32'h40400000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100);
    tab[2] = mk(32'h7f7fffff, 32'h7f7fffff, 32'h7f800000, 32'h7f800000, 32'h7f800000, 32'h7f800000, 3'b010, 3'b010, 3'b010, 3'b011, 4'b1000);
    tab[3] = mk(32'h7fc00000, 32'h3f800000, 32'h7fc00000, 32'h7fc00001, 32'h7fc00001, 32'h7fc00001, 3'b100, 3'b100, 3'b100, 3'b100, 4'b1110);
    tab[4] = mk(32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0010);
    tab[5] = mk(32'h00800000, 32'h00800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001, 3'b001, 3'b011, 3'b001, 3'b001, 4'b1010);
    tab[6] = mk(32'hffc00000, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 3'b100, 3'b100, 3'b100, 3'b100, 4'b0000);

    for (int i = 0; i < HN; i++) hist[i] = '0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("por");
    reset = 1'b1;

    // Single op with default operands.
    reset_pulses();
    n0 = n;
    plan_agree(32'h3f800000, 32'h40000000, 32'h40400000);
    cycle();
    idle(8);
    chk("single_pulses", pulses, 1);
    chk("single_latency", first_n - n0, ML + 1);
    chk("single_mask", last_mask, 4'b0000);
    chk("single_cmp", cmp_count, 1);
    chk("single_err", err_count, 0);

    // Ten back-to-back agreeing ops.
    do_clear();
    reset_pulses();
    n0 = n;
    for (int j = 0; j < 10; j++) begin
      plan_agree($urandom, $urandom, $urandom);
      cycle();
    end
    idle(8);
    chk("b2b_pulses", pulses, 10);
    chk("b2b_first", first_n - n0, ML + 1);
    chk("b2b_last", last_n - n0, ML + 10);
    chk("b2b_cmp", cmp_count, 10);
    chk("b2b_sticky", err_sticky, 0);

    // Continue mode: op 5 mismatches on variant 2, op 7 on variant 3.
    do_clear();
    for (int j = 0; j < 8; j++) begin
      op_a[j] = $urandom; op_b[j] = $urandom;
      plan_agree(op_a[j], op_b[j], 32'h40400000);
      if (j == 5) p_r[2] = 32'h40400001;
      if (j == 7) p_r[3] = 32'h40400002;
      cycle();
    end
    idle(8);
    chk("cont_err", err_count, 2);
    chk("cont_cmp", cmp_count, 8);
    chk("cont_sticky", err_sticky, 1);
    chk("cont_cap_index", cap_index, 5);
    chk("cont_cap_a", cap_a, op_a[5]);
    chk("cont_cap_b", cap_b, op_b[5]);
    chk("cont_cap_mask", cap_mask, 4'b0100);
    chk("cont_frozen", frozen, 0);

    // Stop-on-first with a flag-only mismatch on variant 1.
    p_sof = 1'b1;
    do_clear();
    reset_pulses();
    plan_agree(32'h7f000000, 32'h7f000000, 32'h7f800000);
    p_f[1] = 3'b010;
    cycle();
    for (int j = 0; j < 3; j++) begin
      plan_agree($urandom, $urandom, $urandom);
      p_r[2] = ~p_r[2];
      cycle();
    end
    idle(8);
    chk("sof_pulses", pulses, 4);
    chk("sof_cap_mask", cap_mask, 4'b0010);
    chk("sof_frozen", frozen, 1);
    chk("sof_cmp_hold", cmp_count, 1);
    chk("sof_err_hold", err_count, 1);
    p_sof = 1'b0;
    do_clear();
    chk("sof_clr_cmp", cmp_count, 0);
    chk("sof_clr_err", err_count, 0);
    chk("sof_clr_frozen", frozen, 0);
    chk("sof_clr_sticky", err_sticky, 0);

    // Saturation on the 4-bit counter instance.
    do_clear();
    for (int j = 0; j < 20; j++) begin
      plan_agree($urandom, $urandom, $urandom);
      p_r[3] = p_r[3] ^ 32'h1;
      cycle();
    end
    idle(8);
    chk("sat_small_err", s_err_count, 15);
    chk("sat_small_cmp", s_cmp_count, 15);
    chk("sat_err", err_count, 20);
    chk("sat_cmp", cmp_count, 20);

    // Asynchronous reset with three ops in flight.
    for (int j = 0; j < 3; j++) begin
      plan_agree($urandom, $urandom, $urandom);
      p_r[1] = ~p_r[1];
      cycle();
    end
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    for (int i = 0; i < HN; i++) hist[i].v = 1'b0;
    model_zero();
    e_valid = 1'b0;
    @(posedge clk);
    n++;
    @(negedge clk);
    reset = 1'b1;
    reset_pulses();
    idle(10);
    chk("rst_no_pulse", pulses, 0);

    // Vector table, one isolated op per entry.
    for (int j = 0; j < 7; j++) begin
      reset_pulses();
      n0 = n;
      p_v = 1'b1; p_a = tab[j].a; p_b = tab[j].b; p_r = tab[j].r; p_f = tab[j].f;
      cycle();
      idle(7);
      chk($sformatf("tab%0d_pulses", j), pulses, 1);
      chk($sformatf("tab%0d_latency", j), first_n - n0, ML + 1);
      chk($sformatf("tab%0d_mask", j), last_mask, tab[j].exp_mask);
    end

    // Random traffic with occasional clear and stop_on_first changes.
    do_clear();
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(3) != 0) begin
        plan_agree($urandom, $urandom, $urandom);
        for (int i = 0; i < NV; i++) begin
          p_f[i] = 3'($urandom_range(7));
          if (i > 0) p_f[i] = p_f[0];
          if ($urandom_range(7) == 0) p_r[i] = p_r[i] ^ (32'h1 << $urandom_range(31));
          if ($urandom_range(9) == 0) p_f[i] = p_f[i] ^ (3'b001 << $urandom_range(2));
        end
      end
      p_clr = ($urandom_range(59) == 0);
      if ($urandom_range(49) == 0) p_sof = ~p_sof;
      cycle();
    end
    p_sof = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
